// File: rtl/ad79x8_sequencer.sv
// ad79x8_sequencer
// Channel sequencer in front of the AD79x8 SPI interface block. It runs the
// two power-up dummy frames, then scans the enabled channels round-robin.
// Each data frame writes the next channel address, and the returned word is
// split into channel and sample. Because the converter pipelines by one
// frame, the address that comes back in a frame is the one written in the
// frame before it.
module ad79x8_sequencer #(
    parameter int   RESOLUTION = 12,     // 12 = AD7928, 10 = AD7918, 8 = AD7908
    parameter logic RANGE      = 1'b0,   // 0: 0..2*REFIN, 1: 0..REFIN
    parameter logic CODING     = 1'b1,   // 1: straight binary
    parameter int   TIMEOUT    = 24      // longest allowed WAIT_DONE stay
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  ch_mask,
    output logic [15:0] adc_cmd,
    output logic        adc_initiate,
    input  logic        adc_ready,
    input  logic [15:0] adc_data,
    output logic        res_valid,
    output logic [2:0]  res_channel,
    output logic [11:0] res_data,
    output logic        res_addr_err,
    output logic        busy,
    output logic        err
);

    localparam int SHIFT = 12 - RESOLUTION;
    localparam int WCW   = ($clog2(TIMEOUT + 1) < 2) ? 2 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_PWRUP0,
        S_PWRUP1,
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CAPTURE
    } state_t;

    // frm_cnt: 0/1 = power-up frame in progress, 2 = power-up done and no
    // data frame issued yet, 3 = scanning.
    state_t           state, state_n;
    logic [1:0]       frm_cnt, frm_n;
    logic [WCW-1:0]   wait_cnt, wait_n;
    logic [2:0]       cur_ch, cur_n;
    logic [2:0]       exp_ch, exp_n;
    logic [2:0]       nxt_ch;
    logic [15:0]      cmd_n;
    logic             init_n;
    logic             vld_n;
    logic [2:0]       rch_n;
    logic [11:0]      rdat_n;
    logic             aerr_n;
    logic             busy_n;
    logic             err_n;

    // Bit 15 of the result frame is the leading zero and carries nothing.
    logic unused_lead;
    assign unused_lead = adc_data[15];

    // First set mask bit strictly after cur, wrapping 7->0; the distance-8
    // step lands back on cur so a single-channel mask repeats that channel.
    function automatic logic [2:0] next_chan(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] c;
        logic [2:0] r;
        r = cur;
        for (int i = 8; i >= 1; i--) begin
            c = cur + 3'(i);
            if (mask[c]) r = c;
        end
        return r;
    endfunction

    // Round-robin pick for the next ISSUE.
    always_comb begin
        nxt_ch = next_chan(ch_mask, cur_ch);
    end

    // Next-state and registered-output values.
    always_comb begin
        state_n = state;
        frm_n   = frm_cnt;
        wait_n  = wait_cnt;
        cur_n   = cur_ch;
        exp_n   = exp_ch;
        cmd_n   = adc_cmd;
        init_n  = 1'b0;
        vld_n   = 1'b0;
        rch_n   = res_channel;
        rdat_n  = res_data;
        aerr_n  = 1'b0;
        err_n   = err;

        case (state)
            S_PWRUP0, S_PWRUP1: begin
                // Waiting on ready also lets a frame left in flight by a
                // reset finish before the first dummy frame goes out.
                if (adc_ready) begin
                    cmd_n   = 16'hFFFF;
                    init_n  = 1'b1;
                    wait_n  = '0;
                    state_n = S_WAIT_BUSY;
                end
            end

            S_IDLE: begin
                // A timeout halts the scan until the next reset.
                if (enable && ch_mask != 8'h00 && !err) state_n = S_ISSUE;
            end

            S_ISSUE: begin
                if (ch_mask == 8'h00) begin
                    state_n = S_IDLE;
                end else if (adc_ready) begin
                    cmd_n   = {1'b1, 1'b0, 1'b0, nxt_ch, 2'b11, 1'b0, 1'b0,
                               RANGE, CODING, 4'b0000};
                    init_n  = 1'b1;
                    cur_n   = nxt_ch;
                    wait_n  = '0;
                    state_n = S_WAIT_BUSY;
                    // The first data frame after power-up returns channel 0,
                    // which exp_ch already holds from reset.
                    if (frm_cnt == 2'd2) frm_n = 2'd3;
                    else                 exp_n = cur_ch;
                end
            end

            S_WAIT_BUSY: begin
                if (!adc_ready) begin
                    wait_n  = '0;
                    state_n = S_WAIT_DONE;
                end else if (wait_cnt == WCW'(2)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end

            S_WAIT_DONE: begin
                if (adc_ready) begin
                    state_n = S_CAPTURE;
                end else if (wait_cnt == WCW'(TIMEOUT)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    wait_n = wait_cnt + WCW'(1);
                end
            end

            S_CAPTURE: begin
                if (frm_cnt < 2'd2) begin
                    // Power-up frame: result is discarded.
                    frm_n   = frm_cnt + 2'd1;
                    state_n = (frm_cnt == 2'd0) ? S_PWRUP1 : S_IDLE;
                end else begin
                    vld_n   = 1'b1;
                    rch_n   = adc_data[14:12];
                    rdat_n  = adc_data[11:0] >> SHIFT;
                    aerr_n  = (adc_data[14:12] != exp_ch);
                    state_n = (enable && ch_mask != 8'h00) ? S_ISSUE : S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_PWRUP0;
            frm_cnt      <= 2'd0;
            wait_cnt     <= '0;
            cur_ch       <= 3'd7;
            exp_ch       <= 3'd0;
            adc_cmd      <= 16'hFFFF;
            adc_initiate <= 1'b0;
            res_valid    <= 1'b0;
            res_channel  <= 3'd0;
            res_data     <= 12'd0;
            res_addr_err <= 1'b0;
            busy         <= 1'b1;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            frm_cnt      <= frm_n;
            wait_cnt     <= wait_n;
            cur_ch       <= cur_n;
            exp_ch       <= exp_n;
            adc_cmd      <= cmd_n;
            adc_initiate <= init_n;
            res_valid    <= vld_n;
            res_channel  <= rch_n;
            res_data     <= rdat_n;
            res_addr_err <= aerr_n;
            busy         <= busy_n;
            err          <= err_n;
        end
    end

endmodule

// File: tb/tb_ad79x8_sequencer.sv
// Bench for ad79x8_sequencer: a 12-bit and a 10-bit instance share one
// loopback ADC model (they run in lockstep). The model pushes the expected
// result of every data frame to a queue as it returns the word; the result
// monitor pops and compares when res_valid appears.
module tb_ad79x8_sequencer;

    localparam int TO       = 24;
    localparam int BUSY_LEN = 5;
    localparam int M_NORM   = 0;  // correct address returned
    localparam int M_FIX    = 1;  // return 16'h3ABC
    localparam int M_WRONG  = 2;  // corrupt the returned address
    localparam int M_STUCK  = 3;  // ready never drops
    localparam int M_NODONE = 4;  // ready drops, never returns

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] d12;
        logic [11:0] d10;
        logic        aerr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  ch_mask = 8'h00;
    logic        adc_ready = 1'b1;
    logic [15:0] adc_data = 16'h0000;

    logic [15:0] adc_cmd, cmd10;
    logic        adc_initiate, init10;
    logic        res_valid, vld10;
    logic [2:0]  res_channel, ch10;
    logic [11:0] res_data, dat10;
    logic        res_addr_err, aerr10;
    logic        busy, busy10;
    logic        err, err10;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_init = 0;
    int          n_pop = 0;
    int          mode = M_NORM;
    int          mdl_cnt = 0;
    int          frame_no = 0;
    logic [2:0]  last_addr = 3'd0;
    logic [2:0]  tb_cur = 3'd7;
    logic [15:0] mdl_cmd = 16'hFFFF;
    logic [15:0] last_cmd = 16'hFFFF;
    exp_t        q[$];

    always #5 clk = ~clk;

    ad79x8_sequencer #(.RESOLUTION(12)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .adc_cmd(adc_cmd), .adc_initiate(adc_initiate), .adc_ready(adc_ready),
        .adc_data(adc_data), .res_valid(res_valid), .res_channel(res_channel),
        .res_data(res_data), .res_addr_err(res_addr_err), .busy(busy), .err(err)
    );

    ad79x8_sequencer #(.RESOLUTION(10)) dut10 (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .adc_cmd(cmd10), .adc_initiate(init10), .adc_ready(adc_ready),
        .adc_data(adc_data), .res_valid(vld10), .res_channel(ch10),
        .res_data(dat10), .res_addr_err(aerr10), .busy(busy10), .err(err10)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] rr_next(input logic [7:0] m, input logic [2:0] c);
        logic [2:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            r = r + 3'd1;
            if (m[r]) return r;
        end
        return c;
    endfunction

    // One cycle: ADC model, command checks and result scoreboard.
    task automatic tick();
        exp_t        e;
        logic [2:0]  ret;
        logic [11:0] smp;
        logic [15:0] ecmd;
        @(negedge clk);
        if (!rst) begin
            if (res_valid) begin
                if (q.size() == 0) begin
                    chk("res_unexpected", 32'(res_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    n_pop++;
                    chk("res_ch",   32'(res_channel),  32'(e.ch));
                    chk("res_d12",  32'(res_data),     32'(e.d12));
                    chk("res_aerr", 32'(res_addr_err), 32'(e.aerr));
                    chk("res_v10",  32'(vld10),        32'd1);
                    chk("res_ch10", 32'(ch10),         32'(e.ch));
                    chk("res_d10",  32'(dat10),        32'(e.d10));
                end
            end
            if (adc_initiate) begin
                n_init++;
                if (frame_no < 2) begin
                    ecmd = 16'hFFFF;
                end else begin
                    tb_cur = rr_next(ch_mask, tb_cur);
                    ecmd = 16'h8310 | (16'(tb_cur) << 10);
                end
                chk("cmd",    32'(adc_cmd), 32'(ecmd));
                chk("cmd10",  32'(cmd10),   32'(ecmd));
                chk("init10", 32'(init10),  32'd1);
                last_cmd = adc_cmd;
                if (mode != M_STUCK) begin
                    adc_ready = 1'b0;
                    mdl_cnt   = BUSY_LEN;
                    mdl_cmd   = adc_cmd;
                end
            end else if (!adc_ready) begin
                chk("cmd_hold", 32'(adc_cmd), 32'(mdl_cmd));
                if (mode != M_NODONE) begin
                    mdl_cnt--;
                    if (mdl_cnt == 0) begin
                        smp = 12'($urandom);
                        ret = last_addr;
                        if (mode == M_WRONG) ret = ret ^ 3'd1;
                        if (mode == M_FIX) adc_data = 16'h3ABC;
                        else               adc_data = {1'b0, ret, smp};
                        if (frame_no >= 2) begin
                            if (mode == M_FIX)
                                e = '{3'd3, 12'hABC, 12'h2AF, (last_addr != 3'd3)};
                            else
                                e = '{ret, smp, {2'b00, smp[11:2]}, (mode == M_WRONG)};
                            q.push_back(e);
                            last_addr = mdl_cmd[12:10];
                        end
                        frame_no++;
                        adc_ready = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        adc_ready = 1'b1;
        mode      = M_NORM;
        q.delete();
        frame_no  = 0;
        last_addr = 3'd0;
        tb_cur    = 3'd7;
        tick();
        tick();
        chk("rst_cmd",  32'(adc_cmd),      32'hFFFF);
        chk("rst_init", 32'(adc_initiate), 32'd0);
        chk("rst_vld",  32'(res_valid),    32'd0);
        chk("rst_ch",   32'(res_channel),  32'd0);
        chk("rst_data", 32'(res_data),     32'd0);
        chk("rst_aerr", 32'(res_addr_err), 32'd0);
        chk("rst_err",  32'(err),          32'd0);
        chk("rst_busy", 32'(busy),         32'd1);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < lim) begin
            tick();
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_pops(input string tag, input int n, input int lim);
        int k;
        int p0;
        k  = 0;
        p0 = n_pop;
        while (n_pop - p0 < n && k < lim) begin
            tick();
            k++;
        end
        chk(tag, 32'(n_pop - p0), 32'(n));
    endtask

    task automatic wait_init(input string tag, input int lim);
        int k;
        int i0;
        k  = 0;
        i0 = n_init;
        while (n_init == i0 && k < lim) begin
            tick();
            k++;
        end
        chk(tag, 32'(n_init - i0), 32'd1);
    endtask

    task automatic wait_midframe(input string tag, input int lim);
        int k;
        k = 0;
        while (adc_ready !== 1'b0 && k < lim) begin
            tick();
            k++;
        end
        chk(tag, 32'(adc_ready), 32'd0);
    endtask

    initial begin
        int i0;
        int p0;
        int k;

        // Power-up: two dummy frames, no results, then idle.
        do_reset();
        i0 = n_init;
        wait_idle("pwrup_idle", 100);
        chk("pwrup_frames", 32'(n_init - i0), 32'd2);
        chk("pwrup_nores",  32'(n_pop),       32'd0);

        // Two-channel scan: addresses 0,2,0,2...
        ch_mask = 8'b0000_0101;
        enable  = 1'b1;
        wait_pops("scan_05", 6, 300);

        // Single channel repeats, then a fixed 16'h3ABC return.
        ch_mask = 8'h01;
        wait_pops("scan_01", 3, 200);
        mode = M_FIX;
        wait_pops("fix_3abc", 2, 200);
        mode = M_NORM;
        wait_pops("fix_flush", 2, 200);

        // Mask change mid-frame lands on the next command.
        wait_midframe("mid_sw", 50);
        ch_mask = 8'h80;
        wait_init("mask_sw_init", 50);
        chk("mask_sw_addr", 32'(last_cmd[12:10]), 32'd7);
        wait_pops("scan_80", 3, 200);

        // Wrong address from the converter.
        mode = M_WRONG;
        wait_pops("wrong_addr", 3, 200);
        mode = M_NORM;
        wait_pops("wrong_flush", 2, 200);

        // enable drops mid-frame: that frame's result still comes out.
        wait_midframe("mid_en", 50);
        p0 = n_pop;
        enable = 1'b0;
        wait_idle("en_drop_idle", 60);
        chk("en_drop_res", 32'(n_pop - p0), 32'd1);
        chk("en_drop_q",   32'(q.size()),   32'd0);

        // Empty mask issues nothing.
        ch_mask = 8'h00;
        enable  = 1'b1;
        i0 = n_init;
        repeat (30) tick();
        chk("mask0_noinit", 32'(n_init - i0), 32'd0);
        chk("mask0_busy",   32'(busy),        32'd0);

        // Ready never drops: error three cycles after the pulse, then halt.
        mode    = M_STUCK;
        ch_mask = 8'h01;
        wait_init("stuck_init", 20);
        tick();
        tick();
        chk("stuck_err_early", 32'(err), 32'd0);
        tick();
        chk("stuck_err",   32'(err),   32'd1);
        chk("stuck_err10", 32'(err10), 32'd1);
        chk("stuck_busy",  32'(busy),  32'd0);
        i0 = n_init;
        repeat (30) tick();
        chk("stuck_halt", 32'(n_init - i0), 32'd0);

        // Ready never returns: error after the WAIT_DONE budget.
        enable = 1'b0;
        do_reset();
        wait_idle("pwrup2_idle", 100);
        mode   = M_NODONE;
        enable = 1'b1;
        wait_init("nodone_init", 20);
        repeat (TO) tick();
        chk("nodone_err_early", 32'(err), 32'd0);
        k = 0;
        while (err !== 1'b1 && k < 4) begin
            tick();
            k++;
        end
        chk("nodone_err",   32'(err),    32'd1);
        chk("nodone_busy",  32'(busy),   32'd0);
        chk("nodone_busy10", 32'(busy10), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
